ovl_fire_collector: RTL and testbench

OVL_FIRE_COLLECTOR -- requirements
Module: ovl_fire_collector

---
 rtl/ovl_fire_pkg.sv | 23 ++
 rtl/ovl_fire_fifo.sv | 63 ++++++
 rtl/ovl_fire_collector.sv | 184 ++++++++++++++++++
 tb/tb_ovl_fire_collector.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ovl_fire_pkg.sv
// Shared constants and helpers for the OVL fire collector: fire bus bit layout
// and a saturating adder used by the per-class event counters.
package ovl_fire_pkg;

   localparam int FIRE_ASSERT = 0;
   localparam int FIRE_XCHECK = 1;
   localparam int FIRE_COVER  = 2;
   localparam int FIRE_W      = 3;
   localparam int IDX_W       = 5;

   // Adds b to a and clamps the result at max instead of wrapping.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, max}) begin
         return max;
      end
      return sum[31:0];
   endfunction

endpackage

// File: rtl/ovl_fire_fifo.sv
// Synchronous event queue with clear. A push while full is accepted only when a
// pop happens in the same cycle; otherwise it is dropped and the caller flags it.
module ovl_fire_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // Head reads as zero when empty so the read port never shows stale data.
   assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok && !clear) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects OVL checker fire buses into per-class counters, a first-failure record
// and an event queue. Define OVL_FIRE_COLLECTOR_COVER_EN to build the cover counter.
module ovl_fire_collector
   import ovl_fire_pkg::*;
#(
   parameter int num_checkers = 4,
   parameter int count_width  = 16,
   parameter int fifo_depth   = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           clear,
   input  logic [num_checkers*FIRE_W-1:0] fire_in,
   output logic [count_width-1:0]         assert_count,
   output logic [count_width-1:0]         xcheck_count,
   output logic [count_width-1:0]         cover_count,
   output logic                           first_valid,
   output logic [IDX_W-1:0]               first_index,
   output logic [count_width-1:0]         first_time,
   output logic                           evt_valid,
   input  logic                           evt_ready,
   output logic [IDX_W-1:0]               evt_index,
   output logic [count_width-1:0]         evt_time,
   output logic                           overflow
);

   localparam int          EVT_W   = IDX_W + count_width;
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << count_width) - 64'd1);

   logic [num_checkers-1:0] a_vec, x_vec;
   logic [5:0]              a_pop, x_pop;
   logic [IDX_W-1:0]        low_idx;
   logic                    any_assert;

   logic [count_width-1:0]  assert_q, assert_d;
   logic [count_width-1:0]  xcheck_q, xcheck_d;
   logic [count_width-1:0]  ts_q, ts_d;
   logic                    first_valid_q, first_valid_d;
   logic [IDX_W-1:0]        first_index_q, first_index_d;
   logic [count_width-1:0]  first_time_q, first_time_d;
   logic                    overflow_q, overflow_d;

   logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [EVT_W-1:0]        fifo_dout;

   always_comb begin
      a_vec   = '0;
      x_vec   = '0;
      a_pop   = '0;
      x_pop   = '0;
      low_idx = '0;
      for (int k = 0; k < num_checkers; k++) begin
         a_vec[k] = fire_in[k*FIRE_W + FIRE_ASSERT];
         x_vec[k] = fire_in[k*FIRE_W + FIRE_XCHECK];
         a_pop    = a_pop + 6'(a_vec[k]);
         x_pop    = x_pop + 6'(x_vec[k]);
      end
      // Scan downward so the lowest firing checker wins.
      for (int k = num_checkers - 1; k >= 0; k--) begin
         if (a_vec[k]) low_idx = IDX_W'(k);
      end
   end

   assign any_assert = |a_vec;
   assign fifo_push  = enable && !clear && any_assert;
   assign fifo_pop   = evt_valid && evt_ready;

   always_comb begin
      assert_d      = assert_q;
      xcheck_d      = xcheck_q;
      first_valid_d = first_valid_q;
      first_index_d = first_index_q;
      first_time_d  = first_time_q;
      overflow_d    = overflow_q;
      ts_d          = ts_q + count_width'(1);
      if (clear) begin
         assert_d      = '0;
         xcheck_d      = '0;
         first_valid_d = 1'b0;
         first_index_d = '0;
         first_time_d  = '0;
         overflow_d    = 1'b0;
         ts_d          = '0;
      end else begin
         if (enable) begin
            assert_d = count_width'(sat_add(32'(assert_q), 32'(a_pop), CNT_MAX));
            xcheck_d = count_width'(sat_add(32'(xcheck_q), 32'(x_pop), CNT_MAX));
            if (any_assert && !first_valid_q) begin
               first_valid_d = 1'b1;
               first_index_d = low_idx;
               first_time_d  = ts_q;
            end
         end
         if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         assert_q      <= '0;
         xcheck_q      <= '0;
         ts_q          <= '0;
         first_valid_q <= 1'b0;
         first_index_q <= '0;
         first_time_q  <= '0;
         overflow_q    <= 1'b0;
      end else begin
         assert_q      <= assert_d;
         xcheck_q      <= xcheck_d;
         ts_q          <= ts_d;
         first_valid_q <= first_valid_d;
         first_index_q <= first_index_d;
         first_time_q  <= first_time_d;
         overflow_q    <= overflow_d;
      end
   end

`ifdef OVL_FIRE_COLLECTOR_COVER_EN
   logic [num_checkers-1:0] c_vec;
   logic [5:0]              c_pop;
   logic [count_width-1:0]  cover_q, cover_d;

   always_comb begin
      c_vec = '0;
      c_pop = '0;
      for (int k = 0; k < num_checkers; k++) begin
         c_vec[k] = fire_in[k*FIRE_W + FIRE_COVER];
         c_pop    = c_pop + 6'(c_vec[k]);
      end
      cover_d = cover_q;
      if (clear) begin
         cover_d = '0;
      end else if (enable) begin
         cover_d = count_width'(sat_add(32'(cover_q), 32'(c_pop), CNT_MAX));
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) cover_q <= '0;
      else       cover_q <= cover_d;
   end

   assign cover_count = cover_q;
`else
   logic [num_checkers-1:0] unused_cover_bits;

   always_comb begin
      unused_cover_bits = '0;
      for (int k = 0; k < num_checkers; k++) begin
         unused_cover_bits[k] = fire_in[k*FIRE_W + FIRE_COVER];
      end
   end

   assign cover_count = '0;
`endif

   ovl_fire_fifo #(
      .DW    (EVT_W),
      .DEPTH (fifo_depth)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({low_idx, ts_q}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign evt_valid    = !fifo_empty;
   assign evt_index    = fifo_dout[EVT_W-1 -: IDX_W];
   assign evt_time     = fifo_dout[count_width-1:0];

   assign assert_count = assert_q;
   assign xcheck_count = xcheck_q;
   assign first_valid  = first_valid_q;
   assign first_index  = first_index_q;
   assign first_time   = first_time_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Self-checking bench for ovl_fire_collector: directed scenarios plus random
// traffic scored against a queue-based reference model.
module tb_ovl_fire_collector;

   localparam int ND    = 4;
   localparam int CW    = 16;
   localparam int DEPTH = 4;
   localparam int CMAX  = (1 << CW) - 1;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset;
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- main DUT (default parameters) ----------------
   logic          enable, clear, evt_ready;
   logic [ND*3-1:0] fire_in;
   logic [CW-1:0] assert_count, xcheck_count, cover_count, first_time, evt_time;
   logic          first_valid, evt_valid, overflow;
   logic [4:0]    first_index, evt_index;

   ovl_fire_collector u_dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .clear        (clear),
      .fire_in      (fire_in),
      .assert_count (assert_count),
      .xcheck_count (xcheck_count),
      .cover_count  (cover_count),
      .first_valid  (first_valid),
      .first_index  (first_index),
      .first_time   (first_time),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_index    (evt_index),
      .evt_time     (evt_time),
      .overflow     (overflow)
   );

   // ---------------- narrow-counter DUT (count_width = 4) ----------------
   logic          enable4, clear4, evt_ready4;
   logic [ND*3-1:0] fire4;
   logic [3:0]    assert4, xcheck4, cover4, first_time4, evt_time4;
   logic          first_valid4, evt_valid4, overflow4;
   logic [4:0]    first_index4, evt_index4;

   ovl_fire_collector #(.num_checkers(ND), .count_width(4), .fifo_depth(4)) u_dut4 (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable4),
      .clear        (clear4),
      .fire_in      (fire4),
      .assert_count (assert4),
      .xcheck_count (xcheck4),
      .cover_count  (cover4),
      .first_valid  (first_valid4),
      .first_index  (first_index4),
      .first_time   (first_time4),
      .evt_valid    (evt_valid4),
      .evt_ready    (evt_ready4),
      .evt_index    (evt_index4),
      .evt_time     (evt_time4),
      .overflow     (overflow4)
   );

   // ---------------- reference model / scoreboard ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_acnt, m_xcnt, m_ccnt, m_fi, m_ft, m_ts;
   bit          m_fv, m_ovf;
   logic [20:0] exp_q[$];   // {index[4:0], time[15:0]}

   task automatic model_reset();
      m_acnt = 0; m_xcnt = 0; m_ccnt = 0;
      m_fv = 1'b0; m_fi = 0; m_ft = 0; m_ovf = 1'b0; m_ts = 0;
      exp_q.delete();
   endtask

   function automatic int count_cls(input logic [ND*3-1:0] f, input int cls);
      int n = 0;
      for (int k = 0; k < ND; k++) if (f[3*k + cls]) n++;
      return n;
   endfunction

   function automatic int lowest_assert(input logic [ND*3-1:0] f);
      for (int k = 0; k < ND; k++) if (f[3*k]) return k;
      return -1;
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic model_update(input logic en, input logic clr,
                               input logic [ND*3-1:0] f, input logic rdy);
      int  a;
      bit  pop_now, full_pre;
      if (clr) begin
         model_reset();
      end else begin
         pop_now  = rdy && (exp_q.size() > 0);
         full_pre = (exp_q.size() == DEPTH);
         if (pop_now) void'(exp_q.pop_front());
         if (en) begin
            a      = count_cls(f, 0);
            m_acnt = sat(m_acnt + a);
            m_xcnt = sat(m_xcnt + count_cls(f, 1));
`ifdef OVL_FIRE_COLLECTOR_COVER_EN
            m_ccnt = sat(m_ccnt + count_cls(f, 2));
`endif
            if (a > 0) begin
               if (!m_fv) begin
                  m_fv = 1'b1;
                  m_fi = lowest_assert(f);
                  m_ft = m_ts;
               end
               if (!full_pre || pop_now) exp_q.push_back({5'(lowest_assert(f)), 16'(m_ts)});
               else m_ovf = 1'b1;
            end
         end
         m_ts = (m_ts + 1) % (CMAX + 1);
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".assert_count"}, 64'(assert_count), 64'(m_acnt));
      check({tag, ".xcheck_count"}, 64'(xcheck_count), 64'(m_xcnt));
      check({tag, ".cover_count"},  64'(cover_count),  64'(m_ccnt));
      check({tag, ".first_valid"},  64'(first_valid),  64'(m_fv));
      if (m_fv) begin
         check({tag, ".first_index"}, 64'(first_index), 64'(m_fi));
         check({tag, ".first_time"},  64'(first_time),  64'(m_ft));
      end
      check({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
      check({tag, ".evt_valid"}, 64'(evt_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         check({tag, ".evt_index"}, 64'(evt_index), 64'(exp_q[0][20:16]));
         check({tag, ".evt_time"},  64'(evt_time),  64'(exp_q[0][15:0]));
      end
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge: drive, clock once, score, sample at the next falling edge.
   task automatic step(input string tag, input logic en, input logic clr,
                       input logic [ND*3-1:0] f, input logic rdy);
      enable = en; clear = clr; fire_in = f; evt_ready = rdy;
      @(posedge clock);
      model_update(en, clr, f, rdy);
      @(negedge clock);
      check_all(tag);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      reset = 1'b1;
      enable = 1'b0; clear = 1'b0; fire_in = '0; evt_ready = 1'b0;
      enable4 = 1'b0; clear4 = 1'b0; fire4 = '0; evt_ready4 = 1'b1;
      model_reset();
      repeat (2) @(negedge clock);
      check_all("reset");
      reset = 1'b0;

      // Checkers 1 and 3 assert at timestamp 5.
      for (int i = 0; i < 5; i++) step("idle", 1'b1, 1'b0, '0, 1'b0);
      step("ts5_fire", 1'b1, 1'b0, 12'h208, 1'b0);
      check("ts5.assert_count", 64'(assert_count), 64'd2);
      check("ts5.first_index",  64'(first_index),  64'd1);
      check("ts5.first_time",   64'(first_time),   64'd5);
      check("ts5.evt_entry",    64'({evt_valid, evt_index, evt_time}), {43'd0, 1'b1, 5'd1, 16'd5});
      step("ts5_drain", 1'b1, 1'b0, '0, 1'b1);
      check("ts5.drained", 64'(evt_valid), 64'd0);

      // Enable low suppresses counting and enqueue.
      step("disabled", 1'b0, 1'b0, 12'hFFF, 1'b0);

      // Five failing cycles against a stalled reader overflow a depth-4 queue.
      step("ovf_clear", 1'b1, 1'b1, '0, 1'b0);
      for (int i = 0; i < 5; i++) step("ovf_fill", 1'b1, 1'b0, 12'h040, 1'b0);
      check("ovf.overflow",   64'(overflow), 64'd1);
      check("ovf.head_time",  64'(evt_time), 64'd0);
      for (int i = 0; i < 5; i++) step("ovf_drain", 1'b1, 1'b0, '0, 1'b1);

      // Full queue with simultaneous push and pop keeps occupancy and no overflow.
      step("pp_clear", 1'b1, 1'b1, '0, 1'b0);
      for (int i = 0; i < 4; i++) step("pp_fill", 1'b1, 1'b0, 12'h001, 1'b0);
      for (int i = 0; i < 3; i++) step("pp_both", 1'b1, 1'b0, 12'h008, 1'b1);
      check("pp.overflow", 64'(overflow), 64'd0);
      for (int i = 0; i < 5; i++) step("pp_drain", 1'b1, 1'b0, '0, 1'b1);

      // Clear wins over a same-cycle assertion fire.
      step("clr_pre", 1'b1, 1'b0, 12'h24A, 1'b0);
      step("clr_fire", 1'b1, 1'b1, 12'h001, 1'b0);
      check("clr.first_valid", 64'(first_valid), 64'd0);
      check("clr.evt_valid",   64'(evt_valid),   64'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0),
              12'($urandom & $urandom), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset with a pending event discards it immediately.
      for (int i = 0; i < 3; i++) step("ar_fill", 1'b1, 1'b0, 12'h200, 1'b0);
      check("ar.pre_valid", 64'(evt_valid), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("ar.evt_valid",    64'(evt_valid),    64'd0);
      check("ar.evt_index",    64'(evt_index),    64'd0);
      check("ar.evt_time",     64'(evt_time),     64'd0);
      check("ar.assert_count", 64'(assert_count), 64'd0);
      check("ar.first_valid",  64'(first_valid),  64'd0);
      check("ar.overflow",     64'(overflow),     64'd0);
      check("ar.cover_count",  64'(cover_count),  64'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step("ar_after", 1'b1, 1'b0, '0, 1'b1);

      // Narrow counter saturates at 15 after 20 single-checker xcheck cycles.
      enable4 = 1'b1;
      fire4   = 12'h002;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clock);
         @(negedge clock);
         check("sat4.xcheck_count", 64'(xcheck4), 64'((n > 15) ? 15 : n));
      end
      check("sat4.assert_count", 64'(assert4), 64'd0);
      enable4 = 1'b0;
      fire4   = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
